// File: rtl/fp_pkg.sv
// fp_pkg: shared custom-float defaults, status flag codes and width helpers
// for the shared multiplier slice.
package fp_pkg;
    localparam int EXP_DEF = 5;
    localparam int FRA_DEF = 10;

    typedef enum logic [2:0] {
        FLAG_NORMAL = 3'd0,
        FLAG_ZERO   = 3'd1,
        FLAG_INF    = 3'd2,
        FLAG_NAN    = 3'd3,
        FLAG_UNDER  = 3'd4
    } flag_e;

    function automatic int word_w(int e, int f);
        return e + f + 1;
    endfunction

    function automatic int id_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cmult.sv
// cmult: combinational custom-float multiplier; subnormal inputs flush to zero,
// round to nearest even, overflow saturates to infinity.
module cmult import fp_pkg::*; #(
    parameter int EXP = EXP_DEF,
    parameter int FRA = FRA_DEF
) (
    input  logic             reset,
    input  logic             valid,
    input  logic [EXP+FRA:0] a,
    input  logic [EXP+FRA:0] b,
    output logic [EXP+FRA:0] y,
    output logic [2:0]       flag
);
    localparam logic [EXP-1:0] EMAX = '1;
    localparam int BIAS = 2 ** (EXP - 1) - 1;
    logic [EXP-1:0] ea, eb;
    logic [FRA-1:0] fa, fb, frac;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nan, inf, zero, ovf, unf, sgn, rnd;
    logic [2*FRA+1:0] prod, nprod;
    logic [FRA+1:0] mant;
    int e;
    always_comb begin
        sgn    = a[EXP+FRA] ^ b[EXP+FRA];
        ea     = a[EXP+FRA-1:FRA];
        eb     = b[EXP+FRA-1:FRA];
        fa     = a[FRA-1:0];
        fb     = b[FRA-1:0];
        a_zero = ea == '0;
        b_zero = eb == '0;
        a_inf  = ea == EMAX && fa == '0;
        b_inf  = eb == EMAX && fb == '0;
        a_nan  = ea == EMAX && fa != '0;
        b_nan  = eb == EMAX && fb != '0;
        nan    = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        inf    = a_inf | b_inf;
        zero   = a_zero | b_zero;
        prod   = {{(FRA+1){1'b0}}, 1'b1, fa} * {{(FRA+1){1'b0}}, 1'b1, fb};
        nprod  = prod[2*FRA+1] ? prod : prod << 1;
        // guard bit decides; ties go to the even mantissa
        rnd    = nprod[FRA] & (nprod[FRA+1] | (|nprod[FRA-1:0]));
        mant   = {1'b0, nprod[2*FRA+1:FRA+1]} + {{(FRA+1){1'b0}}, rnd};
        frac   = mant[FRA+1] ? mant[FRA:1] : mant[FRA-1:0];
        e      = int'(ea) + int'(eb) - BIAS + int'(prod[2*FRA+1]) + int'(mant[FRA+1]);
        ovf    = e >= int'(EMAX);
        unf    = e <= 0;
        flag   = nan ? FLAG_NAN : inf ? FLAG_INF : zero ? FLAG_ZERO :
                 ovf ? FLAG_INF : unf ? FLAG_UNDER : FLAG_NORMAL;
        y      = nan ? {1'b0, EMAX, 1'b1, {(FRA-1){1'b0}}} :
                 (inf || (ovf && !zero)) ? {sgn, EMAX, {FRA{1'b0}}} :
                 (zero || unf) ? {sgn, {(EXP+FRA){1'b0}}} :
                 {sgn, e[EXP-1:0], frac};
        if (reset || !valid) begin
            y    = '0;
            flag = FLAG_NORMAL;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr;
// the pointer register is owned by the caller.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic any;
    always_comb begin
        idx = '0;
        any = 1'b0;
        // descending scan so the closest request after ptr is written last
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                idx = IDW'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
        gnt = (en && any) ? {{(NREQ-1){1'b0}}, 1'b1} << idx : '0;
    end
endmodule

// File: rtl/fmul_share_arb.sv
// fmul_share_arb: round-robin shares one cmult between NREQ requesters through a
// two-stage operand/result pipeline. FMUL_STICKY_FLAG_EN adds per-requester sticky flags.
module fmul_share_arb import fp_pkg::*; #(
    parameter int EXP  = EXP_DEF,
    parameter int FRA  = FRA_DEF,
    parameter int NREQ = 4,
    parameter int IDW  = id_w(NREQ)
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*(EXP+FRA+1)-1:0]   req_a,
    input  logic [NREQ*(EXP+FRA+1)-1:0]   req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDW-1:0]                rsp_id,
    output logic [EXP+FRA:0]              rsp_y,
    output logic [2:0]                    rsp_flag
`ifdef FMUL_STICKY_FLAG_EN
    ,
    input  logic                          sticky_clr,
    output logic [NREQ*3-1:0]             sticky_flag
`endif
);
    localparam int W = word_w(EXP, FRA);
    logic s0_v, s1_v, s0_adv, s1_adv;
    logic [IDW-1:0] ptr, s0_id, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [W-1:0] s0_a, s0_b, y;
    logic [2:0] flag;

    assign s1_adv    = !s1_v || rsp_ready;
    assign s0_adv    = !s0_v || s1_adv;
    assign req_ready = gnt;
    assign rsp_valid = s1_v;

    // grants are suppressed while reset is held so nothing is accepted then
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .en (s0_adv && aresetn),
        .gnt(gnt),
        .idx(gnt_idx)
    );

    cmult #(.EXP(EXP), .FRA(FRA)) u_cmult (
        .reset(1'b0),
        .valid(1'b1),
        .a    (s0_a),
        .b    (s0_b),
        .y    (y),
        .flag (flag)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s0_v     <= 1'b0;
            s1_v     <= 1'b0;
            ptr      <= '0;
            s0_id    <= '0;
            s0_a     <= '0;
            s0_b     <= '0;
            rsp_id   <= '0;
            rsp_y    <= '0;
            rsp_flag <= '0;
        end else begin
            if (s0_adv) begin
                s0_v <= |gnt;
                if (|gnt) begin
                    s0_a  <= req_a[gnt_idx*W +: W];
                    s0_b  <= req_b[gnt_idx*W +: W];
                    s0_id <= gnt_idx;
                    ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            if (s1_adv) begin
                s1_v <= s0_v;
                if (s0_v) begin
                    rsp_id   <= s0_id;
                    rsp_y    <= y;
                    rsp_flag <= flag;
                end
            end
        end
    end

`ifdef FMUL_STICKY_FLAG_EN
    always_ff @(posedge clk) begin
        if (!aresetn || sticky_clr)
            sticky_flag <= '0;
        else if (rsp_valid && rsp_ready)
            sticky_flag[rsp_id*3 +: 3] <= sticky_flag[rsp_id*3 +: 3] | rsp_flag;
    end
`endif
endmodule
